// File: rtl/pcpi_copro_mux_pkg.sv
// Shared state encoding, instruction-field constants and helpers for the PCPI coprocessor mux.
package pcpi_copro_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Wide enough for any legal timeout (< 14 so the core's 16-cycle trap still wins the race).
  localparam int TCNT_W = 4;

  localparam logic [6:0] PCPI_OPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] PCPI_F7_APPROX   = 7'b0000001;

  localparam logic [2:0] APPROX_F3_DUAL16  = 3'b000;
  localparam logic [2:0] APPROX_F3_QUAD_LO = 3'b001;
  localparam logic [2:0] APPROX_F3_QUAD_HI = 3'b010;

  function automatic logic [31:0] approx_insn(input logic [2:0] f3,
                                              input logic [4:0] rd,
                                              input logic [4:0] rs1,
                                              input logic [4:0] rs2);
    return {PCPI_F7_APPROX, rs2, rs1, f3, rd, PCPI_OPC_CUSTOM0};
  endfunction

  function automatic logic is_approx_insn(input logic [31:0] insn);
    logic f3_ok;
    f3_ok = (insn[14:12] == APPROX_F3_DUAL16) ||
            (insn[14:12] == APPROX_F3_QUAD_LO) ||
            (insn[14:12] == APPROX_F3_QUAD_HI);
    return (insn[6:0] == PCPI_OPC_CUSTOM0) && (insn[31:25] == PCPI_F7_APPROX) && f3_ok;
  endfunction

endpackage

// File: rtl/pcpi_copro_mux_resp_sel.sv
// Combinational response selector: the lowest-index ready slave supplies rd/wr.
// The collision flag multi_o exists only when PCPI_MUX_STATS_EN is defined.
module pcpi_resp_sel #(
  parameter int N_SLAVES = 2
) (
  input  logic [N_SLAVES-1:0]    s_ready_i,
  input  logic [N_SLAVES-1:0]    s_wr_i,
  input  logic [32*N_SLAVES-1:0] s_rd_i,
  output logic                   any_ready_o,
  output logic                   sel_wr_o,
  output logic [31:0]            sel_rd_o
`ifdef PCPI_MUX_STATS_EN
  ,
  output logic                   multi_o
`endif
);

  // Scan high to low so the lowest set index is the last (winning) assignment.
  always_comb begin
    sel_wr_o = 1'b0;
    sel_rd_o = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (s_ready_i[i]) begin
        sel_wr_o = s_wr_i[i];
        sel_rd_o = s_rd_i[32*i +: 32];
      end
    end
  end

  assign any_ready_o = |s_ready_i;

`ifdef PCPI_MUX_STATS_EN
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_o = |(s_ready_i & (s_ready_i - N_SLAVES'(1)));
`endif

endmodule

// File: rtl/pcpi_copro_mux.sv
// PCPI coprocessor mux: broadcasts each core request to N slaves and returns the first response.
// Statistics counters and stat_* ports are built only when PCPI_MUX_STATS_EN is defined.
//   state | meaning
//   IDLE  | waiting for a core request
//   ISSUE | request broadcast, waiting for a slave ready/wait or the timeout
//   DRAIN | response returned or abandoned, waiting for the core to drop valid
module pcpi_copro_mux
  import pcpi_copro_mux_pkg::*;
#(
  parameter int N_SLAVES    = 2,
  parameter int TIMEOUT_CYC = 12
) (
  input  logic                   clk_i,
  input  logic                   resetn_i,
  input  logic                   pcpi_valid_i,
  input  logic [31:0]            pcpi_insn_i,
  input  logic [31:0]            pcpi_rs1_i,
  input  logic [31:0]            pcpi_rs2_i,
  output logic                   pcpi_wr_o,
  output logic [31:0]            pcpi_rd_o,
  output logic                   pcpi_wait_o,
  output logic                   pcpi_ready_o,
  output logic [N_SLAVES-1:0]    s_valid_o,
  output logic [31:0]            s_insn_o,
  output logic [31:0]            s_rs1_o,
  output logic [31:0]            s_rs2_o,
  input  logic [N_SLAVES-1:0]    s_wr_i,
  input  logic [32*N_SLAVES-1:0] s_rd_i,
  input  logic [N_SLAVES-1:0]    s_wait_i,
  input  logic [N_SLAVES-1:0]    s_ready_i
`ifdef PCPI_MUX_STATS_EN
  ,
  output logic [31:0]            stat_issued_o,
  output logic [15:0]            stat_timeout_o,
  output logic [15:0]            stat_collide_o
`endif
);

  // Down-counter loaded at issue; expiry is the terminal count seen on an idle ISSUE cycle.
  localparam logic [TCNT_W-1:0] TCNT_LOAD = TCNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [31:0]       insn_q, insn_d;
  logic [31:0]       rs1_q, rs1_d;
  logic [31:0]       rs2_q, rs2_d;
  logic [31:0]       rd_q, rd_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              armed_q, armed_d;
  logic              ready_q, ready_d;
  logic              wr_q, wr_d;
  logic              wait_q, wait_d;

  logic              any_ready;
  logic              sel_wr;
  logic [31:0]       sel_rd;
`ifdef PCPI_MUX_STATS_EN
  logic              multi;
`endif

  pcpi_resp_sel #(
    .N_SLAVES (N_SLAVES)
  ) u_resp_sel (
    .s_ready_i   (s_ready_i),
    .s_wr_i      (s_wr_i),
    .s_rd_i      (s_rd_i),
    .any_ready_o (any_ready),
    .sel_wr_o    (sel_wr),
    .sel_rd_o    (sel_rd)
`ifdef PCPI_MUX_STATS_EN
    ,
    .multi_o     (multi)
`endif
  );

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      insn_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      tcnt_q  <= '0;
      armed_q <= 1'b0;
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      tcnt_q  <= tcnt_d;
      armed_q <= armed_d;
      ready_q <= ready_d;
      wr_q    <= wr_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    insn_d  = insn_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    tcnt_d  = tcnt_q;
    armed_d = armed_q;
    ready_d = 1'b0;
    wr_d    = 1'b0;
    wait_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pcpi_valid_i) begin
          insn_d  = pcpi_insn_i;
          rs1_d   = pcpi_rs1_i;
          rs2_d   = pcpi_rs2_i;
          tcnt_d  = TCNT_LOAD;
          armed_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A core abort outranks a response arriving in the same cycle.
        if (!pcpi_valid_i) begin
          state_d = ST_IDLE;
        end else if (any_ready) begin
          ready_d = 1'b1;
          wr_d    = sel_wr;
          rd_d    = sel_rd;
          state_d = ST_DRAIN;
        end else if (|s_wait_i) begin
          wait_d  = 1'b1;
          armed_d = 1'b0;
        end else if (armed_q) begin
          if (tcnt_q == '0) begin
            state_d = ST_DRAIN;
          end else begin
            tcnt_d = tcnt_q - TCNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!pcpi_valid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Valid drops combinationally on ready so a single-cycle slave cannot fire twice.
  always_comb begin
    s_valid_o = '0;
    if ((state_q == ST_ISSUE) && !any_ready) begin
      s_valid_o = '1;
    end
    s_insn_o     = insn_q;
    s_rs1_o      = rs1_q;
    s_rs2_o      = rs2_q;
    pcpi_ready_o = ready_q;
    pcpi_wr_o    = wr_q;
    pcpi_rd_o    = rd_q;
    pcpi_wait_o  = wait_q;
  end

`ifdef PCPI_MUX_STATS_EN
  logic [31:0] issued_q;
  logic [15:0] timeout_q;
  logic [15:0] collide_q;
  logic        ev_issue;
  logic        ev_timeout;
  logic        ev_collide;

  assign ev_issue   = (state_q == ST_IDLE) && (state_d == ST_ISSUE);
  assign ev_timeout = (state_q == ST_ISSUE) && (state_d == ST_DRAIN) && !ready_d;
  assign ev_collide = (state_q == ST_ISSUE) && multi;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      issued_q  <= '0;
      timeout_q <= '0;
      collide_q <= '0;
    end else begin
      if (ev_issue && (issued_q != '1)) begin
        issued_q <= issued_q + 32'd1;
      end
      if (ev_timeout && (timeout_q != '1)) begin
        timeout_q <= timeout_q + 16'd1;
      end
      if (ev_collide && (collide_q != '1)) begin
        collide_q <= collide_q + 16'd1;
      end
    end
  end

  assign stat_issued_o  = issued_q;
  assign stat_timeout_o = timeout_q;
  assign stat_collide_o = collide_q;
`endif

endmodule
